// File: rtl/window_gen_5x5_pkg.sv
// Shared constants, pixel type and index helpers for the 5x5 window generator
// and the downstream median stage.
package window_gen_5x5_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int KERNEL      = 5;
  localparam int ELEMENT_NUM = KERNEL * KERNEL;
  localparam int LINES       = KERNEL - 1;
  localparam int SEL_W       = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int WIN_W       = DATA_WIDTH * ELEMENT_NUM;

  typedef logic [DATA_WIDTH-1:0] pixel_t;

  // Packed-window element index: row r (0 = oldest line), column c (0 = leftmost).
  function automatic int idx(input int r, input int c);
    return r * KERNEL + c;
  endfunction

  // Line-buffer slot holding tap k (0 = oldest line) when slot 'sel' is being overwritten.
  function automatic logic [SEL_W-1:0] tap_sel(input logic [SEL_W-1:0] sel, input int k);
    int s;
    s = int'(sel) + k;
    if (s >= LINES) begin
      s = s - LINES;
    end else begin
      s = s;
    end
    return SEL_W'(s);
  endfunction

  // Advance the line-slot pointer modulo the number of line buffers.
  function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] sel);
    if (sel == SEL_W'(LINES - 1)) begin
      return {SEL_W{1'b0}};
    end else begin
      return sel + SEL_W'(1);
    end
  endfunction

endpackage

// File: rtl/window_gen_5x5_if.sv
// Pixel-stream in / window-stream out bundle for window_gen_5x5.
// master = pixel source / window sink, slave = the window generator.
interface window_gen_5x5_if #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
);
  import window_gen_5x5_pkg::*;

  localparam int X_W = $clog2(IMG_WIDTH);
  localparam int Y_W = $clog2(IMG_HEIGHT);

  logic             in_valid;
  logic             in_sof;
  pixel_t           in_data;
  logic             win_valid;
  logic [WIN_W-1:0] window;
  logic [X_W-1:0]   win_x;
  logic [Y_W-1:0]   win_y;

  modport master (
    output in_valid, in_sof, in_data,
    input  win_valid, window, win_x, win_y
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output win_valid, window, win_x, win_y
  );

endinterface

// File: rtl/window_gen_5x5_line_buffer.sv
// One image line of storage: single-port RAM, synchronous read, read-before-write
// (a write returns the value previously stored at the same address).
module window_gen_5x5_line_buffer
  import window_gen_5x5_pkg::*;
#(
  parameter int DEPTH  = 640,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  pixel_t            wdata,
  output pixel_t            rdata
);

  pixel_t mem_r [DEPTH];
  pixel_t rdata_r;

  // RAM port: old contents are read out while the new value is written.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata_r <= mem_r[addr];
      if (we) begin
        mem_r[addr] <= wdata;
      end
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/window_gen_5x5.sv
// Raster pixel stream -> fully-inside 5x5 windows with centre coordinates.
// Stage 0 tracks the raster position and reads the line buffers; stage 1
// shifts the window register and emits a window when the pixel completes one.
// The line buffers rotate: the slot holding the oldest line (y-4) is overwritten
// with line y, which behaves exactly like a chain of KERNEL-1 line delays.
module window_gen_5x5
  import window_gen_5x5_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input logic           clk,
  input logic           rst_n,
  window_gen_5x5_if.slave bus
);

  localparam int X_W  = $clog2(IMG_WIDTH);
  localparam int Y_W  = $clog2(IMG_HEIGHT);
  localparam int HALF = KERNEL / 2;

  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 1);
  localparam logic [X_W-1:0] X_MIN  = X_W'(KERNEL - 1);
  localparam logic [Y_W-1:0] Y_MIN  = Y_W'(KERNEL - 1);
  localparam logic [X_W-1:0] X_OFF  = X_W'(HALF);
  localparam logic [Y_W-1:0] Y_OFF  = Y_W'(HALF);

  // raster position of the next expected pixel
  logic [X_W-1:0]   col_r;
  logic [Y_W-1:0]   row_r;
  logic [SEL_W-1:0] sel_r;
  logic             frame_active_r;

  // position of the pixel presented this cycle
  logic             acc_s;
  logic [X_W-1:0]   cur_col_s;
  logic [Y_W-1:0]   cur_row_s;
  logic [SEL_W-1:0] cur_sel_s;

  // stage 1: pixel waiting for its line-buffer taps
  logic             d1_valid_r;
  pixel_t           d1_data_r;
  logic [X_W-1:0]   d1_x_r;
  logic [Y_W-1:0]   d1_y_r;
  logic [SEL_W-1:0] d1_sel_r;

  pixel_t           tap_rd_s [LINES];
  pixel_t           sr_r      [KERNEL][KERNEL];
  pixel_t           sr_next_s [KERNEL][KERNEL];
  logic [WIN_W-1:0] win_next_s;
  logic             complete_s;

  logic             win_valid_r;
  logic [WIN_W-1:0] window_r;
  logic [X_W-1:0]   win_x_r;
  logic [Y_W-1:0]   win_y_r;

  // Accept a pixel when it starts a frame or belongs to the running one; sof restarts at (0,0).
  always_comb begin
    acc_s = bus.in_valid & (bus.in_sof | frame_active_r);
    if (bus.in_sof) begin
      cur_col_s = {X_W{1'b0}};
      cur_row_s = {Y_W{1'b0}};
      cur_sel_s = {SEL_W{1'b0}};
    end else begin
      cur_col_s = col_r;
      cur_row_s = row_r;
      cur_sel_s = sel_r;
    end
  end

  // Raster counters: wrap col at line end, close the frame after the last pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r          <= {X_W{1'b0}};
      row_r          <= {Y_W{1'b0}};
      sel_r          <= {SEL_W{1'b0}};
      frame_active_r <= 1'b0;
    end else if (acc_s) begin
      if (cur_col_s == X_LAST) begin
        col_r <= {X_W{1'b0}};
        sel_r <= sel_inc(cur_sel_s);
        if (cur_row_s == Y_LAST) begin
          row_r          <= {Y_W{1'b0}};
          frame_active_r <= 1'b0;
        end else begin
          row_r          <= cur_row_s + Y_W'(1);
          frame_active_r <= 1'b1;
        end
      end else begin
        col_r          <= cur_col_s + X_W'(1);
        row_r          <= cur_row_s;
        sel_r          <= cur_sel_s;
        frame_active_r <= 1'b1;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < LINES; g++) begin : g_lb
      window_gen_5x5_line_buffer #(
        .DEPTH (IMG_WIDTH)
      ) u_lb (
        .clk   (clk),
        .en    (acc_s),
        .we    (acc_s && (cur_sel_s == SEL_W'(g))),
        .addr  (cur_col_s),
        .wdata (bus.in_data),
        .rdata (tap_rd_s[g])
      );
    end
  endgenerate

  // Hold the accepted pixel one cycle so it lines up with the RAM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_valid_r <= 1'b0;
      d1_data_r  <= {DATA_WIDTH{1'b0}};
      d1_x_r     <= {X_W{1'b0}};
      d1_y_r     <= {Y_W{1'b0}};
      d1_sel_r   <= {SEL_W{1'b0}};
    end else begin
      d1_valid_r <= acc_s;
      if (acc_s) begin
        d1_data_r <= bus.in_data;
        d1_x_r    <= cur_col_s;
        d1_y_r    <= cur_row_s;
        d1_sel_r  <= cur_sel_s;
      end
    end
  end

  // Next window: shift columns left, new right column = taps (oldest first) + new pixel.
  always_comb begin
    sr_next_s  = sr_r;
    win_next_s = {WIN_W{1'b0}};
    for (int r = 0; r < KERNEL; r++) begin
      for (int c = 0; c < KERNEL - 1; c++) begin
        sr_next_s[r][c] = sr_r[r][c+1];
      end
    end
    for (int r = 0; r < LINES; r++) begin
      sr_next_s[r][KERNEL-1] = tap_rd_s[tap_sel(d1_sel_r, r)];
    end
    sr_next_s[KERNEL-1][KERNEL-1] = d1_data_r;
    for (int r = 0; r < KERNEL; r++) begin
      for (int c = 0; c < KERNEL; c++) begin
        win_next_s[idx(r, c)*DATA_WIDTH +: DATA_WIDTH] = sr_next_s[r][c];
      end
    end
    complete_s = d1_valid_r && (d1_x_r >= X_MIN) && (d1_y_r >= Y_MIN);
  end

  // Window shift register and output registers; outputs hold between windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < KERNEL; r++) begin
        for (int c = 0; c < KERNEL; c++) begin
          sr_r[r][c] <= {DATA_WIDTH{1'b0}};
        end
      end
      win_valid_r <= 1'b0;
      window_r    <= {WIN_W{1'b0}};
      win_x_r     <= {X_W{1'b0}};
      win_y_r     <= {Y_W{1'b0}};
    end else begin
      win_valid_r <= complete_s;
      if (d1_valid_r) begin
        sr_r <= sr_next_s;
      end
      if (complete_s) begin
        window_r <= win_next_s;
        win_x_r  <= d1_x_r - X_OFF;
        win_y_r  <= d1_y_r - Y_OFF;
      end
    end
  end

  assign bus.win_valid = win_valid_r;
  assign bus.window    = window_r;
  assign bus.win_x     = win_x_r;
  assign bus.win_y     = win_y_r;

endmodule

// File: tb/tb_window_gen_5x5.sv
// Self-checking bench for window_gen_5x5 on an 8x6 image. A reference model
// keeps the current frame as a 2-D image and cuts expected windows from it.
module tb_window_gen_5x5;
  import window_gen_5x5_pkg::*;

  localparam int W = 8;
  localparam int H = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  window_gen_5x5_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();

  window_gen_5x5 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [WIN_W-1:0] win;
    int               x;
    int               y;
    int               due;
  } exp_t;

  typedef struct {
    logic [WIN_W-1:0] win;
    int               x;
    int               y;
  } rec_t;

  typedef struct {
    pixel_t base;
    int     gap_max;
    int     exp_count;
    int     ex;
    int     ey;
    pixel_t e0;
    pixel_t e12;
    pixel_t e24;
    pixel_t last12;
  } vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  rec_t got_q[$];

  pixel_t img [H][W];
  bit     m_act = 1'b0;
  int     mx = 0;
  int     my = 0;

  logic [WIN_W-1:0] prev_win = '0;
  int               prev_x = 0;
  int               prev_y = 0;

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [WIN_W-1:0] got, input logic [WIN_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  function automatic pixel_t elem(input logic [WIN_W-1:0] w, input int e);
    return w[e*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  // Reference model: accept/drop by frame rules, store pixel, emit window if fully inside.
  task automatic model_pixel(input bit s, input pixel_t d);
    exp_t e;
    if (s) begin
      m_act = 1'b1;
      mx = 0;
      my = 0;
    end
    if (m_act) begin
      img[my][mx] = d;
      if (mx >= KERNEL - 1 && my >= KERNEL - 1) begin
        e.win = '0;
        for (int r = 0; r < KERNEL; r++)
          for (int c = 0; c < KERNEL; c++)
            e.win[(r*KERNEL+c)*DATA_WIDTH +: DATA_WIDTH] = img[my-KERNEL+1+r][mx-KERNEL+1+c];
        e.x   = mx - KERNEL/2;
        e.y   = my - KERNEL/2;
        e.due = cyc + 2;
        exp_q.push_back(e);
      end
      if (mx == W - 1) begin
        mx = 0;
        if (my == H - 1) m_act = 1'b0;
        else my++;
      end else begin
        mx++;
      end
    end
  endtask

  task automatic drive(input bit v, input bit s, input pixel_t d);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.in_sof   = s;
    bus.in_data  = d;
    if (v && rst_n) model_pixel(s, d);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_part(input pixel_t base, input int n);
    for (int k = 0; k < n; k++)
      drive(1'b1, k == 0, pixel_t'(int'(base) + (k / W) * 16 + (k % W)));
  endtask

  task automatic send_frame(input pixel_t base, input int gap_max, input bit rnd);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (gap_max > 0) idle(int'($urandom_range(0, gap_max)));
        drive(1'b1, (x == 0 && y == 0),
              rnd ? pixel_t'($urandom) : pixel_t'(int'(base) + y * 16 + x));
      end
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_win_valid", WIN_W'(bus.win_valid), '0);
    check("rst_window", bus.window, '0);
    check("rst_win_x", WIN_W'(bus.win_x), '0);
    check("rst_win_y", WIN_W'(bus.win_y), '0);
  endtask

  // Monitor: compare each window against the model; outputs must hold when idle.
  initial begin
    exp_t e;
    rec_t g;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.win_valid) begin
          g.win = bus.window;
          g.x   = int'(bus.win_x);
          g.y   = int'(bus.win_y);
          got_q.push_back(g);
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_window: got window at x=%0d y=%0d, required none", g.x, g.y);
          end else begin
            e = exp_q.pop_front();
            check("window", bus.window, e.win);
            check("win_x", WIN_W'(bus.win_x), WIN_W'(e.x));
            check("win_y", WIN_W'(bus.win_y), WIN_W'(e.y));
          end
        end else begin
          check("hold_window", bus.window, prev_win);
          check("hold_win_x", WIN_W'(bus.win_x), WIN_W'(prev_x));
          check("hold_win_y", WIN_W'(bus.win_y), WIN_W'(prev_y));
        end
        if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
          n_chk++;
          n_fail++;
          $display("FAIL latency: window x=%0d y=%0d missing at cycle %0d, required by %0d",
                   exp_q[0].x, exp_q[0].y, cyc, exp_q[0].due);
          void'(exp_q.pop_front());
        end
      end
      prev_win = bus.window;
      prev_x   = int'(bus.win_x);
      prev_y   = int'(bus.win_y);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [3];
    int   off;
    tbl[0] = '{8'h00, 0, 8, 2, 2, 8'h00, 8'h22, 8'h44, 8'h35};
    tbl[1] = '{8'h00, 3, 8, 2, 2, 8'h00, 8'h22, 8'h44, 8'h35};
    tbl[2] = '{8'h80, 0, 8, 2, 2, 8'h80, 8'hA2, 8'hC4, 8'hB5};

    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = 8'h00;
    #12;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven frames, sent back to back; gaps entry checks freeze behaviour.
    got_q.delete();
    foreach (tbl[i]) send_frame(tbl[i].base, tbl[i].gap_max, 1'b0);
    idle(4);
    check("table_total_count", WIN_W'(got_q.size()), WIN_W'(24));
    off = 0;
    foreach (tbl[i]) begin
      if (got_q.size() >= off + tbl[i].exp_count) begin
        check("tbl_first_x", WIN_W'(got_q[off].x), WIN_W'(tbl[i].ex));
        check("tbl_first_y", WIN_W'(got_q[off].y), WIN_W'(tbl[i].ey));
        check("tbl_elem0", WIN_W'(elem(got_q[off].win, 0)), WIN_W'(tbl[i].e0));
        check("tbl_elem12", WIN_W'(elem(got_q[off].win, 12)), WIN_W'(tbl[i].e12));
        check("tbl_elem24", WIN_W'(elem(got_q[off].win, 24)), WIN_W'(tbl[i].e24));
        check("tbl_last_elem12", WIN_W'(elem(got_q[off+tbl[i].exp_count-1].win, 12)),
              WIN_W'(tbl[i].last12));
      end
      off += tbl[i].exp_count;
    end

    // sof at position (3,4): aborted frame yields nothing, restart frame yields 8.
    got_q.delete();
    send_part(8'h00, 4 * W + 3);
    send_frame(8'h40, 0, 1'b0);
    idle(4);
    check("abort_count", WIN_W'(got_q.size()), WIN_W'(8));
    if (got_q.size() > 0) begin
      check("abort_first_x", WIN_W'(got_q[0].x), WIN_W'(2));
      check("abort_first_y", WIN_W'(got_q[0].y), WIN_W'(2));
      check("abort_elem0", WIN_W'(elem(got_q[0].win, 0)), WIN_W'(8'h40));
    end

    // Pixels after the frame end without sof are dropped.
    got_q.delete();
    for (int k = 0; k < 10; k++) drive(1'b1, 1'b0, pixel_t'($urandom));
    idle(4);
    check("drop_count", WIN_W'(got_q.size()), WIN_W'(0));
    send_frame(8'h10, 0, 1'b0);
    idle(4);
    check("after_drop_count", WIN_W'(got_q.size()), WIN_W'(8));
    if (got_q.size() > 0)
      check("after_drop_last12", WIN_W'(elem(got_q[got_q.size()-1].win, 12)), WIN_W'(8'h45));

    // Reset in the middle of a frame, at position (6,4).
    got_q.delete();
    send_part(8'h00, 4 * W + 6);
    idle(3);
    check("pre_reset_count", WIN_W'(got_q.size()), WIN_W'(2));
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    m_act = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, pixel_t'($urandom));
    idle(4);
    check("post_reset_no_sof_count", WIN_W'(got_q.size()), WIN_W'(0));
    send_frame(8'h20, 0, 1'b0);
    idle(4);
    check("post_reset_count", WIN_W'(got_q.size()), WIN_W'(8));
    if (got_q.size() > 0)
      check("post_reset_elem12", WIN_W'(elem(got_q[0].win, 12)), WIN_W'(8'h42));

    // Random pixel values and gaps, checked against the model.
    got_q.delete();
    for (int f = 0; f < 3; f++) send_frame(8'h00, 2, 1'b1);
    idle(4);
    check("random_count", WIN_W'(got_q.size()), WIN_W'(24));
    check("model_queue_empty", WIN_W'(exp_q.size()), WIN_W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
